// File: rtl/issue_select.sv
// Issue select: round-robin grant of up to ISSUE_W ready RS entries into a
// stallable issue register that also tracks branch resolve/squash.
package issue_select_pkg;
  localparam int B_MASK_W = 4;

  typedef struct packed {
    logic [5:0]          dest_tag;
    logic [15:0]         payload;
    logic [B_MASK_W-1:0] b_mask;
    logic                Source1_ready;
    logic                Source2_ready;
  } rs_packet_t;
endpackage

module issue_select
  import issue_select_pkg::*;
#(
  parameter int RS_ENTRIES = 8,
  parameter int ISSUE_W    = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  rs_packet_t [RS_ENTRIES-1:0]    rs_data_next,
  input  logic       [RS_ENTRIES-1:0]    rs_valid_issue,
  input  logic                           fu_stall,
  input  logic       [B_MASK_W-1:0]      b_mm_resolve,
  input  logic                           b_mm_mispred,
  output logic       [RS_ENTRIES-1:0]    rs_data_issuing,
  output rs_packet_t [ISSUE_W-1:0]       issue_packets,
  output logic       [ISSUE_W-1:0]       issue_valid
);

  localparam int PTR_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

  logic       [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  rs_packet_t [ISSUE_W-1:0]    pkt_q, pkt_d;
  logic       [ISSUE_W-1:0]    vld_q, vld_d;

  logic       [RS_ENTRIES-1:0] ready, grant;
  rs_packet_t [ISSUE_W-1:0]    sel_pkt;
  logic       [ISSUE_W-1:0]    sel_vld;
  logic       [PTR_W-1:0]      last_idx, idx;
  logic       [PTR_W:0]        sum;
  logic                        any_grant, hold;
  int                          cnt;

  always_comb begin
    ready = '0;
    for (int j = 0; j < RS_ENTRIES; j++)
      ready[j] = rs_valid_issue[j] & rs_data_next[j].Source1_ready & rs_data_next[j].Source2_ready;
  end

  // An empty issue register never blocks, whatever execute says.
  assign hold = fu_stall & (|vld_q);

  // Scan from rr_ptr upward with wrap; k-th grant in scan order lands in slot k.
  always_comb begin
    grant    = '0;
    sel_pkt  = '0;
    sel_vld  = '0;
    last_idx = '0;
    cnt      = 0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(RS_ENTRIES)) sum = sum - (PTR_W+1)'(RS_ENTRIES);
      idx = sum[PTR_W-1:0];
      if (ready[idx] && (cnt < ISSUE_W)) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < ISSUE_W; k++) begin
          if (k == cnt) begin
            sel_pkt[k] = rs_data_next[idx];
            sel_vld[k] = 1'b1;
          end
        end
        last_idx = idx;
        cnt      = cnt + 1;
      end
    end
    any_grant = (cnt != 0);
  end

  assign rs_data_issuing = (hold || reset) ? '0 : grant;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!hold && any_grant)
      rr_ptr_d = (last_idx == PTR_W'(RS_ENTRIES-1)) ? '0 : last_idx + 1'b1;
  end

  // Branch resolve acts on whatever the register will hold next, held or freshly loaded.
  always_comb begin
    pkt_d = hold ? pkt_q : sel_pkt;
    vld_d = hold ? vld_q : sel_vld;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (b_mm_mispred && (|(b_mm_resolve & pkt_d[k].b_mask))) begin
        pkt_d[k] = '0;
        vld_d[k] = 1'b0;
      end else begin
        pkt_d[k].b_mask = pkt_d[k].b_mask & ~b_mm_resolve;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      pkt_q    <= '0;
      vld_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pkt_q    <= pkt_d;
      vld_q    <= vld_d;
    end
  end

  assign issue_packets = pkt_q;
  assign issue_valid   = vld_q;

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: vector table plus hand sequences for branch resolve/squash,
// with next-cycle register expectations queued and popped after each clock edge.
module tb_issue_select;
  import issue_select_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  rs_packet_t [7:0]       rs_data_next;
  logic       [7:0]       rs_valid_issue;
  logic                   fu_stall;
  logic       [3:0]       b_mm_resolve;
  logic                   b_mm_mispred;
  logic       [7:0]       rs_data_issuing;
  rs_packet_t [1:0]       issue_packets;
  logic       [1:0]       issue_valid;

  issue_select #(.RS_ENTRIES(8), .ISSUE_W(2)) dut (
    .clock(clock), .reset(reset), .rs_data_next(rs_data_next),
    .rs_valid_issue(rs_valid_issue), .fu_stall(fu_stall),
    .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred),
    .rs_data_issuing(rs_data_issuing), .issue_packets(issue_packets),
    .issue_valid(issue_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [7:0] rdy;
    logic       stall;
    logic [7:0] iss;
    logic [1:0] v;
    int         e0;
    int         e1;
  } vec_t;

  typedef struct packed {
    logic [1:0] v;
    rs_packet_t p0;
    rs_packet_t p1;
  } exp_t;

  vec_t       tbl [14];
  exp_t       sb [$];
  logic [3:0] bm [8];
  int         errors = 0;
  int         checks = 0;

  function automatic rs_packet_t mk(input int id);
    rs_packet_t p;
    p = '0;
    if (id >= 0) begin
      p.dest_tag      = 6'(id);
      p.payload       = 16'hA000 | 16'(id);
      p.b_mask        = bm[id];
      p.Source1_ready = 1'b1;
      p.Source2_ready = 1'b1;
    end
    return p;
  endfunction

  // Not-ready entries fail in one of three ways so each term of the ready AND matters.
  task automatic set_rs(input logic [7:0] rdy);
    for (int j = 0; j < 8; j++) begin
      rs_data_next[j]   = mk(j);
      rs_valid_issue[j] = 1'b1;
      if (!rdy[j]) begin
        case (j % 3)
          0:       rs_valid_issue[j] = 1'b0;
          1:       rs_data_next[j].Source1_ready = 1'b0;
          default: rs_data_next[j].Source2_ready = 1'b0;
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [7:0] rdy,
                      input logic stall, input logic [3:0] res, input logic mis,
                      input logic [7:0] exp_iss, input exp_t e);
    exp_t got;
    reset        = rst;
    set_rs(rdy);
    fu_stall     = stall;
    b_mm_resolve = res;
    b_mm_mispred = mis;
    #2;
    chk({tag, ".issuing"}, 64'(rs_data_issuing), 64'(exp_iss));
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    chk({tag, ".valid"}, 64'(issue_valid),      64'(got.v));
    chk({tag, ".pkt0"},  64'(issue_packets[0]), 64'(got.p0));
    chk({tag, ".pkt1"},  64'(issue_packets[1]), 64'(got.p1));
  endtask

  initial begin
    exp_t       e;
    rs_packet_t p3c;
    for (int j = 0; j < 8; j++) bm[j] = 4'b0000;

    //            rst   ready         stall iss          v      e0  e1
    tbl[0]  = '{1'b1, 8'b1111_1111, 1'b0, 8'b0000_0000, 2'b00, -1, -1};
    tbl[1]  = '{1'b0, 8'b0010_1010, 1'b0, 8'b0000_1010, 2'b11,  1,  3};
    tbl[2]  = '{1'b0, 8'b0010_0000, 1'b0, 8'b0010_0000, 2'b01,  5, -1};
    tbl[3]  = '{1'b0, 8'b1000_0001, 1'b0, 8'b1000_0001, 2'b11,  7,  0};
    tbl[4]  = '{1'b0, 8'b0000_0100, 1'b1, 8'b0000_0000, 2'b11,  7,  0};
    tbl[5]  = '{1'b0, 8'b0000_0100, 1'b1, 8'b0000_0000, 2'b11,  7,  0};
    tbl[6]  = '{1'b0, 8'b0000_0100, 1'b1, 8'b0000_0000, 2'b11,  7,  0};
    tbl[7]  = '{1'b0, 8'b0000_0100, 1'b0, 8'b0000_0100, 2'b01,  2, -1};
    tbl[8]  = '{1'b0, 8'b0000_0000, 1'b0, 8'b0000_0000, 2'b00, -1, -1};
    tbl[9]  = '{1'b0, 8'b0001_0000, 1'b1, 8'b0001_0000, 2'b01,  4, -1};
    tbl[10] = '{1'b0, 8'b1111_1111, 1'b0, 8'b0110_0000, 2'b11,  5,  6};
    tbl[11] = '{1'b0, 8'b1111_1111, 1'b0, 8'b1000_0001, 2'b11,  7,  0};
    tbl[12] = '{1'b1, 8'b1111_1111, 1'b0, 8'b0000_0000, 2'b00, -1, -1};
    tbl[13] = '{1'b0, 8'b1000_0001, 1'b0, 8'b1000_0001, 2'b11,  0,  7};

    for (int i = 0; i < 14; i++) begin
      e.v  = tbl[i].v;
      e.p0 = mk(tbl[i].e0);
      e.p1 = mk(tbl[i].e1);
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rdy, tbl[i].stall,
           4'b0000, 1'b0, tbl[i].iss, e);
    end

    // Branch sequences: entry 3 depends on branch bit 1, entry 1 on nothing.
    bm[3] = 4'b0010;
    p3c = mk(3);
    p3c.b_mask = 4'b0000;

    e = '{2'b11, mk(1), mk(3)};
    step("br_load", 1'b0, 8'b0000_1010, 1'b0, 4'b0000, 1'b0, 8'b0000_1010, e);
    e = '{2'b01, mk(1), rs_packet_t'('0)};
    step("br_squash_held", 1'b0, 8'b0000_0000, 1'b1, 4'b0010, 1'b1, 8'b0000_0000, e);
    step("br_keep_squashed", 1'b0, 8'b0000_0000, 1'b1, 4'b0000, 1'b0, 8'b0000_0000, e);
    e = '{2'b11, mk(1), mk(3)};
    step("br_reload", 1'b0, 8'b0000_1010, 1'b0, 4'b0000, 1'b0, 8'b0000_1010, e);
    e = '{2'b11, mk(1), p3c};
    step("br_resolve_held", 1'b0, 8'b0000_0000, 1'b1, 4'b0010, 1'b0, 8'b0000_0000, e);
    e = '{2'b01, mk(1), rs_packet_t'('0)};
    step("br_squash_load", 1'b0, 8'b0000_1010, 1'b0, 4'b0010, 1'b1, 8'b0000_1010, e);
    e = '{2'b11, mk(1), p3c};
    step("br_resolve_load", 1'b0, 8'b0000_1010, 1'b0, 4'b0010, 1'b0, 8'b0000_1010, e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
